// File: rtl/sdram_burst_pkg.sv
// Shared types and constants for the SDRAM burst responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Working-address step per beat, in bytes
  localparam int BEAT_BYTES_32 = 4;
  localparam int BEAT_BYTES_16 = 2;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ADDR_W     = 26;
  localparam int DEF_LEN_W      = 11;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data, occupancy count, empty and full.
// Latency: a pushed entry is visible on pop_dat the cycle after the push.
// Backpressure: push is ignored while full, pop is ignored while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy update; depth is a power of two so pointers wrap naturally
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/sdram_burst_responder.sv
// Burst-read responder: turns one burst request into sequential word reads and streams beats back.
// Latency: first mem_rd 1 cycle after burst_rd; mem_q_valid in N gives burst_data_valid in N+1.
// Backpressure: reads stall on mem_ready or a full return path; the initiator never stalls.
// Optional sticky error flag built only when SDRAM_BURST_RESP_OVERRUN_EN is defined.
module sdram_burst_responder
  import sdram_burst_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic              sdram_clk,
  input  logic              nRESET,
  input  logic              burst_rd,
  input  logic [ADDR_W-1:0] burst_addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              burst_32bit,
  output logic [31:0]       burst_data,
  output logic              burst_data_valid,
  output logic              burst_data_done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_q,
  input  logic              mem_q_valid,
  output logic              busy,
  output logic              err_overrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  delivered_q, delivered_d;
  logic              mode_q, mode_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  // The tag FIFO holds one entry per read in flight, so its occupancy is the outstanding count.
  logic [CW-1:0]     tag_cnt, ret_cnt;
  logic              tag_empty, tag_full, ret_empty, ret_full;
  logic              tag_head;
  logic [31:0]       ret_head;
  logic [CW:0]       in_flight;
  logic              rd_ok, beat_vld, ret_push, ret_pop, out_vld;
  logic [31:0]       beat_dat, out_dat;
  logic [ADDR_W-1:0] step;

  // Read gating, half-word steering and return-path bypass
  always_comb begin
    in_flight = {1'b0, tag_cnt} + {1'b0, ret_cnt};
    rd_ok     = (state_q == ISSUE) && (issued_q < len_q) && mem_ready &&
                !tag_full && !ret_full && (in_flight < (CW+1)'(FIFO_DEPTH));
    beat_vld  = mem_q_valid && !tag_empty;
    if (mode_q)        beat_dat = mem_q;
    else if (tag_head) beat_dat = {16'h0, mem_q[31:16]};
    else               beat_dat = {16'h0, mem_q[15:0]};
    // An empty FIFO lets the incoming beat go straight to the output register
    ret_pop  = !ret_empty;
    ret_push = beat_vld && !ret_empty;
    out_vld  = !ret_empty || beat_vld;
    out_dat  = ret_empty ? beat_dat : ret_head;
    step     = mode_q ? ADDR_W'(BEAT_BYTES_32) : ADDR_W'(BEAT_BYTES_16);
  end

  // Next-state, counters and output registers
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    mode_d      = mode_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    data_d      = out_vld ? out_dat : data_q;
    valid_d     = out_vld;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (burst_rd) begin
          addr_d      = burst_addr;
          len_d       = burst_len;
          mode_d      = burst_32bit;
          issued_d    = '0;
          delivered_d = '0;
          if (burst_len == '0) begin
            done_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rd_ok) begin
          addr_d   = addr_q + step;
          issued_d = issued_q + 1'b1;
        end
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (delivered_q == len_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && out_vld) begin
      delivered_d = delivered_q + 1'b1;
      done_d      = ((delivered_q + 1'b1) == len_q);
    end
  end

  // State registers
  always_ff @(posedge sdram_clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      issued_q    <= '0;
      delivered_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_ret_fifo (
    .clk      (sdram_clk),
    .rst_n    (nRESET),
    .push     (ret_push),
    .push_dat (beat_dat),
    .pop      (ret_pop),
    .pop_dat  (ret_head),
    .count    (ret_cnt),
    .empty    (ret_empty),
    .full     (ret_full)
  );

  sync_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk      (sdram_clk),
    .rst_n    (nRESET),
    .push     (rd_ok),
    .push_dat (addr_q[1]),
    .pop      (beat_vld),
    .pop_dat  (tag_head),
    .count    (tag_cnt),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  assign burst_data       = data_q;
  assign burst_data_valid = valid_q;
  assign burst_data_done  = done_q;
  assign mem_rd           = rd_ok;
  assign mem_addr         = addr_q & ~ADDR_W'(3);
  assign busy             = (state_q != IDLE);

`ifdef SDRAM_BURST_RESP_OVERRUN_EN
  logic err_q, err_d;

  // Sticky flag: request while busy, or read data with nothing outstanding
  always_comb begin
    err_d = err_q || (burst_rd && (state_q != IDLE)) || (mem_q_valid && tag_empty);
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge sdram_clk or negedge nRESET) begin
    if (!nRESET) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_overrun = err_q;
`else
  assign err_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder: table of bursts plus reset, zero-length and busy sequences.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
// A behavioural memory returns {~addr[15:0], addr[15:0]} (two fixed words at 0x200/0x204) after a per-burst latency.
`timescale 1ns/1ps
module tb_sdram_burst_responder;

  localparam int DEPTH = 8;
  localparam int AW    = 26;
  localparam int LW    = 11;
`ifdef SDRAM_BURST_RESP_OVERRUN_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          sdram_clk = 1'b0;
  logic          nRESET = 1'b0;
  logic          burst_rd = 1'b0;
  logic [AW-1:0] burst_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic          burst_32bit = 1'b0;
  logic [31:0]   burst_data;
  logic          burst_data_valid, burst_data_done;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_q = '0;
  logic          mem_q_valid = 1'b0;
  logic          busy, err_overrun;

  sdram_burst_responder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .LEN_W(LW)) dut (
    .sdram_clk        (sdram_clk),
    .nRESET           (nRESET),
    .burst_rd         (burst_rd),
    .burst_addr       (burst_addr),
    .burst_len        (burst_len),
    .burst_32bit      (burst_32bit),
    .burst_data       (burst_data),
    .burst_data_valid (burst_data_valid),
    .burst_data_done  (burst_data_done),
    .mem_rd           (mem_rd),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_q            (mem_q),
    .mem_q_valid      (mem_q_valid),
    .busy             (busy),
    .err_overrun      (err_overrun)
  );

  always #5 sdram_clk = ~sdram_clk;

  typedef struct {
    logic [25:0]      addr;
    logic [10:0]      len;
    logic             m32;
    int               lat;
    int               rdy;   // 0: always ready, 1: every other cycle, 2: two of three cycles
    int               mid;   // cycle offset of an extra burst_rd during the burst (0 = none)
    logic [3:0][25:0] ea;    // expected mem_addr of the first four reads
    logic [3:0][31:0] ed;    // expected burst_data of the first four beats
  } row_t;

  row_t rows[7];

  int checks = 0;
  int errors = 0;
  int cyc = 0, cur_lat = 1, rdy_mode = 0, inflight = 0, max_inflight = 0;
  int first_rd_cyc = -1, first_vld_cyc = -1, last_vld_cyc = -1, done_cnt = 0, done_cyc = -1;
  logic [25:0] cap_addr[$];
  logic [31:0] cap_dat[$];
  logic [25:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] word_of(input logic [25:0] a);
    if (a == 26'h200) return 32'hAAAA5555;
    if (a == 26'h204) return 32'hCCCC3333;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle_begin();
    logic [25:0] a;
    int          d;
    @(posedge sdram_clk);
    #1;
    cyc++;
    burst_rd = 1'b0;
    case (rdy_mode)
      1:       mem_ready = (cyc % 2 == 0);
      2:       mem_ready = (cyc % 3 != 0);
      default: mem_ready = 1'b1;
    endcase
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      d = pend_due.pop_front();
      mem_q_valid = 1'b1;
      mem_q = word_of(a);
      inflight--;
    end else begin
      mem_q_valid = 1'b0;
      mem_q = 32'hDEADBEEF;
    end
  endtask

  task automatic cycle_end();
    @(negedge sdram_clk);
    if (mem_rd && mem_ready) begin
      cap_addr.push_back(mem_addr);
      pend_addr.push_back(mem_addr);
      pend_due.push_back(cyc + cur_lat);
      inflight++;
      if (inflight > max_inflight) max_inflight = inflight;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (burst_data_valid) begin
      cap_dat.push_back(burst_data);
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      last_vld_cyc = cyc;
    end
    if (burst_data_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_capture();
    cap_addr.delete();
    cap_dat.delete();
    first_rd_cyc = -1;
    first_vld_cyc = -1;
    last_vld_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    max_inflight = inflight;
  endtask

  task automatic set_row(input int n, input logic [25:0] a, input int len, input logic m, input int lat,
                         input int rdy, input int mid, input logic [25:0] a0, input logic [25:0] a1,
                         input logic [25:0] a2, input logic [25:0] a3, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    rows[n].addr = a;
    rows[n].len  = 11'(len);
    rows[n].m32  = m;
    rows[n].lat  = lat;
    rows[n].rdy  = rdy;
    rows[n].mid  = mid;
    rows[n].ea[0] = a0; rows[n].ea[1] = a1; rows[n].ea[2] = a2; rows[n].ea[3] = a3;
    rows[n].ed[0] = d0; rows[n].ed[1] = d1; rows[n].ed[2] = d2; rows[n].ed[3] = d3;
  endtask

  task automatic run_burst(input int id, input row_t r);
    int          c0;
    bit          got;
    logic [25:0] ea;
    logic [31:0] ed;
    clear_capture();
    cur_lat  = r.lat;
    rdy_mode = r.rdy;
    cycle_begin();
    burst_rd = 1'b1; burst_addr = r.addr; burst_len = r.len; burst_32bit = r.m32;
    c0 = cyc;
    cycle_end();
    got = 1'b0;
    for (int k = 1; k < 400 && !got; k++) begin
      cycle_begin();
      if (k == r.mid) begin
        burst_rd = 1'b1; burst_addr = 26'h5000; burst_len = 11'd2; burst_32bit = 1'b1;
      end
      cycle_end();
      if (k == 1) check($sformatf("b%0d_busy_during", id), busy, 1);
      if (done_cnt > 0) got = 1'b1;
    end
    check($sformatf("b%0d_done_seen_before_timeout", id), got, 1);
    cycle_begin();
    cycle_end();
    check($sformatf("b%0d_busy_after_done", id), busy, 0);
    repeat (4) begin
      cycle_begin();
      cycle_end();
    end
    check($sformatf("b%0d_read_count", id), cap_addr.size(), r.len);
    check($sformatf("b%0d_beat_count", id), cap_dat.size(), r.len);
    check($sformatf("b%0d_done_count", id), done_cnt, 1);
    check($sformatf("b%0d_done_cycle_vs_last_beat", id), done_cyc, last_vld_cyc);
    check($sformatf("b%0d_inflight_le_depth", id), max_inflight <= DEPTH, 1);
    if (r.rdy == 0) begin
      check($sformatf("b%0d_first_rd_latency", id), first_rd_cyc - c0, 1);
      check($sformatf("b%0d_return_latency", id), first_vld_cyc - first_rd_cyc, r.lat + 1);
      check($sformatf("b%0d_back_to_back", id), last_vld_cyc - first_vld_cyc, r.len - 1);
    end
    for (int i = 0; i < int'(r.len); i++) begin
      if (i < 4) begin
        ea = r.ea[i];
        ed = r.ed[i];
      end else begin
        ea = r.addr + 26'(4 * i);
        ed = word_of(ea);
      end
      if (i < cap_addr.size()) check($sformatf("b%0d_mem_addr%0d", id, i), cap_addr[i], ea);
      if (i < cap_dat.size())  check($sformatf("b%0d_data%0d", id, i), cap_dat[i], ed);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    set_row(0, 26'h100, 4, 1'b1, 3, 0, 0, 26'h100, 26'h104, 26'h108, 26'h10C,
            32'hFEFF0100, 32'hFEFB0104, 32'hFEF70108, 32'hFEF3010C);
    set_row(1, 26'h202, 3, 1'b0, 2, 0, 0, 26'h200, 26'h204, 26'h204, 26'h0,
            32'h0000AAAA, 32'h00003333, 32'h0000CCCC, 32'h0);
    set_row(2, 26'h3FFFFFC, 2, 1'b1, 1, 0, 0, 26'h3FFFFFC, 26'h0, 26'h0, 26'h0,
            32'h0003FFFC, 32'hFFFF0000, 32'h0, 32'h0);
    set_row(3, 26'h300, 4, 1'b0, 4, 1, 0, 26'h300, 26'h300, 26'h304, 26'h304,
            32'h00000300, 32'h0000FCFF, 32'h00000304, 32'h0000FCFB);
    set_row(4, 26'h1000, 16, 1'b1, 12, 2, 0, 26'h1000, 26'h1004, 26'h1008, 26'h100C,
            32'hEFFF1000, 32'hEFFB1004, 32'hEFF71008, 32'hEFF3100C);
    set_row(5, 26'h400, 6, 1'b1, 3, 0, 3, 26'h400, 26'h404, 26'h408, 26'h40C,
            32'hFBFF0400, 32'hFBFB0404, 32'hFBF70408, 32'hFBF3040C);
    set_row(6, 26'h2000, 2, 1'b1, 2, 0, 0, 26'h2000, 26'h2004, 26'h0, 26'h0,
            32'hDFFF2000, 32'hDFFB2004, 32'h0, 32'h0);

    // Reset state
    repeat (2) begin
      cycle_begin();
      cycle_end();
    end
    check("reset_burst_data", burst_data, 0);
    check("reset_valid", burst_data_valid, 0);
    check("reset_done", burst_data_done, 0);
    check("reset_mem_rd", mem_rd, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err_overrun, 0);
    cycle_begin();
    nRESET = 1'b1;
    cycle_end();

    // Table of bursts; row 5 carries a request issued while busy
    for (int i = 0; i < 6; i++) begin
      run_burst(i, rows[i]);
      if (i == 4) check("err_clean_traffic", err_overrun, 0);
    end
    check("err_after_busy_request", err_overrun, EXP_ERR);

    // Zero-length burst
    clear_capture();
    rdy_mode = 0;
    cycle_begin();
    burst_rd = 1'b1; burst_addr = 26'h800; burst_len = '0; burst_32bit = 1'b1;
    cycle_end();
    cycle_begin();
    cycle_end();
    check("len0_done_next_cycle", burst_data_done, 1);
    check("len0_no_valid", burst_data_valid, 0);
    cycle_begin();
    cycle_end();
    check("len0_busy_low", busy, 0);
    check("len0_done_single", burst_data_done, 0);
    repeat (3) begin
      cycle_begin();
      cycle_end();
    end
    check("len0_no_reads", cap_addr.size(), 0);
    check("len0_no_beats", cap_dat.size(), 0);

    // Reset with three reads outstanding
    clear_capture();
    cur_lat = 10;
    cycle_begin();
    burst_rd = 1'b1; burst_addr = 26'h2000; burst_len = 11'd8; burst_32bit = 1'b1;
    cycle_end();
    repeat (3) begin
      cycle_begin();
      cycle_end();
    end
    check("rst_reads_before_reset", cap_addr.size(), 3);
    cycle_begin();
    nRESET = 1'b0;
    #1;
    cycle_end();
    check("rst_burst_data", burst_data, 0);
    check("rst_valid", burst_data_valid, 0);
    check("rst_done", burst_data_done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_overrun, 0);
    clear_capture();
    cycle_begin();
    nRESET = 1'b1;
    cycle_end();
    repeat (16) begin
      cycle_begin();
      cycle_end();
    end
    check("rst_late_data_dropped", cap_dat.size(), 0);
    check("rst_no_reads_after", cap_addr.size(), 0);
    check("err_after_late_data", err_overrun, EXP_ERR);
    run_burst(6, rows[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_burst_responder.md
# sdram_burst_responder

Responder end of the SDRAM burst-read interface (`burst_rd`/`burst_addr`/`burst_len`/`burst_32bit` in; `burst_data`/`burst_data_valid`/`burst_data_done` out) used by the graphics CROM fetch path. It accepts one burst request at a time and converts it into sequential word reads on a pipelined 32-bit memory port. Returned words are buffered in a small FIFO and streamed back to the initiator, which cannot stall. It sits in the `sdram_clk` domain between the graphics MUX and the SDRAM command engine.

## Interface
- `FIFO_DEPTH`, 8: return-buffer depth; power of two, at least 4.
- `ADDR_W`, 26: byte-address width.
- `LEN_W`, 11: burst length width, in beats.
- `sdram_clk` in 1: sole clock.
- `nRESET` in 1: reset, **asynchronous, active-low**.
- `burst_rd` in 1: single-cycle request strobe.
- `burst_addr` in ADDR_W: start byte address.
- `burst_len` in LEN_W: number of beats.
- `burst_32bit` in 1: 1 = 32-bit beats, 0 = 16-bit beats.
- `burst_data` out 32: beat data.
- `burst_data_valid` out 1: beat strobe, one cycle per beat.
- `burst_data_done` out 1: end-of-burst pulse.
- `mem_rd` out 1: word read request.
- `mem_addr` out ADDR_W: word-aligned address; bits [1:0] always 0.
- `mem_ready` in 1: the port accepts `mem_rd` in any cycle where `mem_ready`=1.
- `mem_q` in 32: read data, returned in order.
- `mem_q_valid` in 1: read data strobe.
- `busy` out 1: a burst is in progress.
- `err_overrun` out 1: sticky flag (see Configuration).

## Operation
- **Reset values.** All outputs are 0, the state is IDLE, the FIFO is empty, and all counters are 0.
- **IDLE.**
  - On `burst_rd`=1, latch the address, length and mode.
  - Clear the issue and deliver counters.
  - Go to ISSUE and assert `busy`.
- **ISSUE.**
  - Assert `mem_rd` while all of the following hold: issued < len, `mem_ready`=1, and outstanding + FIFO occupancy < FIFO_DEPTH.
  - Each accepted read advances the working address by 4 in 32-bit mode or by 2 in 16-bit mode. `mem_addr` is the working address with bits [1:0] cleared.
  - When issued reaches len, go to DRAIN.
- **Outstanding count.** Increment on an accepted `mem_rd`; decrement on `mem_q_valid`.
- **Half-select tag FIFO.** Each accepted read pushes working address bit [1] into a tag FIFO of depth FIFO_DEPTH. The tag is popped on `mem_q_valid`.
- **Return data.**
  - On `mem_q_valid`, push the beat into the return FIFO.
  - 32-bit mode: push `mem_q` unchanged.
  - 16-bit mode: tag=0 pushes {16'h0, `mem_q`[15:0]}; tag=1 pushes {16'h0, `mem_q`[31:16]}.
- **Output.** Whenever the return FIFO is non-empty, pop one entry per cycle onto `burst_data` with `burst_data_valid`=1. `burst_data` holds its last value when not valid.
- **DRAIN.** When delivered reaches len, return to IDLE and drop `busy`.
- **End of burst.** `burst_data_done` pulses in the same cycle as the last `burst_data_valid`.
- **Zero length.** `burst_len`=0 issues no reads and produces no data. `burst_data_done` pulses 1 cycle after acceptance and the block returns to IDLE.
- **Request while busy.** A `burst_rd` seen outside IDLE is ignored; the current burst is unaffected.
- **Unexpected data.** `mem_q_valid` arriving with zero outstanding reads is dropped.
- **Address wrap.** The working address wraps modulo 2^ADDR_W.
- **Reset mid-burst.** All state clears at once; later `mem_q_valid` pulses are dropped, because outstanding = 0.

## Timing
- `burst_rd` is sampled at cycle 0; the earliest `mem_rd` is in cycle 1.
- `mem_q_valid` in cycle N with the FIFO empty gives `burst_data_valid` in cycle N+1 (registered fall-through).
- Throughput is 1 beat per cycle when `mem_ready` stays high and memory latency is below FIFO_DEPTH.
- The earliest accepted next request is 1 cycle after `burst_data_done`.

## Configuration
- `SDRAM_BURST_RESP_OVERRUN_EN` **defined**: `err_overrun` sets on any of these events and clears only on reset:
  - `burst_rd` seen while busy;
  - unexpected `mem_q_valid`.
- `SDRAM_BURST_RESP_OVERRUN_EN` **undefined**: `err_overrun` is tied to 0 and no detection logic is built. Functional behaviour is otherwise identical.

## Structure
- **Shared package `sdram_burst_pkg`:**
  - state enum `{IDLE, ISSUE, DRAIN}`;
  - beat-size constants (4 and 2);
  - default width localparams.
- **Sub-module `sync_fifo`:**
  - single-clock, parameterised width and depth;
  - provides count, empty and full;
  - instantiated twice: return data (32 bits) and tags (1 bit).

## Test plan
- 32-bit burst: addr 0x000100, len 4, memory latency 3, `mem_ready`=1.
  - `mem_addr` = 0x100, 0x104, 0x108, 0x10C.
  - 4 consecutive valid beats with the matching data.
  - `burst_data_done` on the 4th beat.
- 16-bit burst: addr 0x000202, len 3, memory returns 0xAAAA5555 / 0xCCCC3333.
  - `mem_addr` = 0x200, 0x204, 0x204.
  - Data 0x0000AAAA, 0x00003333, 0x0000CCCC.
- Backpressure: `mem_ready` toggling, memory latency 12, FIFO_DEPTH 8, len 16.
  - Never more than 8 in flight.
  - All 16 beats delivered in order.
- len=0 → no `mem_rd`; `burst_data_done` 1 cycle after the request; `busy` low after that.
- `burst_rd` issued mid-burst → ignored, and the original burst completes. `err_overrun`=1 when the macro is defined, 0 when it is not.
- Assert `nRESET` low with 3 reads outstanding.
  - All outputs go to 0 at once.
  - The 3 late `mem_q_valid` pulses produce no `burst_data_valid`.
  - A new len 2 burst completes correctly.
